// File: rtl/mvu_pe_popcount_acc_if.sv
// Bus bundle for mvu_pe_popcount_acc: the input beat stream and the
// accumulated dot-product result stream.
//
// Handshake: valid-only, there is no ready. A beat transfers on every clk
// edge where in_v=1, and the producer may assert in_v on any cycle. out_v
// is a one-cycle pulse: out_add carries a new result exactly on the cycles
// where out_v=1, and holds its last value otherwise. The consumer must take
// the result on the pulse cycle.
interface mvu_pe_popcount_acc_if #(
  parameter int SIMD  = 32,
  parameter int TDstI = 16
);
  logic             in_v;
  logic [SIMD-1:0]  in_bits;
  logic             out_v;
  logic [TDstI-1:0] out_add;

  // The producer of XNOR bits (master) drives the beats and observes the results.
  modport master (output in_v, in_bits, input out_v, out_add);
  // The PE reduction unit (slave) consumes the beats and produces the results.
  modport slave  (input in_v, in_bits, output out_v, out_add);
endinterface

// File: rtl/mvu_pe_popcount_acc.sv
// mvu_pe_popcount_acc: pipelined popcount of SIMD binary XNOR products,
// accumulated over SF synapse folds, with one result pulse per output neuron.
//
// Pipeline (PIPE_MID=0): the beat is captured in s0 at edge k, the popcount
// is registered in s1 at k+1, the accumulator is updated at k+2, and the
// output register is loaded at k+3. PIPE_MID=1 adds a half-sum register
// between s0 and s1, which moves every later stage one edge later.
// The output register reads the completed accumulator, so the next group's
// first beat overwrites the accumulator on the same edge that pulses out_v.
//
// Optional build macro MVU_PE_BIPOLAR_EN: the result becomes the signed
// bipolar dot product 2*x - SIMD*SF. When the macro is undefined, the
// result is the plain unsigned popcount sum.
module mvu_pe_popcount_acc #(
  parameter int SIMD     = 32,
  parameter int SF       = 4,
  parameter int TDstI    = 16,
  parameter int PIPE_MID = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mvu_pe_popcount_acc_if.slave  bus
);

`ifdef MVU_PE_BIPOLAR_EN
  localparam int BIPOLAR = 1;
`else
  localparam int BIPOLAR = 0;
`endif

  localparam int CW    = $clog2(SIMD + 1);
  localparam int FCW   = (SF > 1) ? $clog2(SF) : 1;
  localparam int REQ_W = $clog2(SIMD * SF + 1) + BIPOLAR;

  // The accumulator must hold SIMD*SF, plus a sign bit in bipolar mode.
  generate
    if (TDstI < REQ_W) begin : g_width_chk
      $error("mvu_pe_popcount_acc: TDstI=%0d is below the required %0d bits", TDstI, REQ_W);
    end
  endgenerate

  // Stage 0 and the fold counter
  logic [FCW-1:0]  r_fold;
  logic            r_s0_v;
  logic            r_s0_first;
  logic            r_s0_last;
  logic [SIMD-1:0] r_s0_bits;
  logic            w_first;
  logic            w_last;

  assign w_first = (r_fold == '0);
  assign w_last  = (r_fold == FCW'(SF - 1));

  // Capture accepted beats with their fold position; the fold counter advances only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fold     <= '0;
      r_s0_v     <= 1'b0;
      r_s0_first <= 1'b0;
      r_s0_last  <= 1'b0;
      r_s0_bits  <= '0;
    end else begin
      r_s0_v <= bus.in_v;
      if (bus.in_v) begin
        r_s0_bits  <= bus.in_bits;
        r_s0_first <= w_first;
        r_s0_last  <= w_last;
        r_fold     <= w_last ? '0 : r_fold + FCW'(1);
      end
    end
  end

  // Popcount tree: two half sums
  logic [CW-1:0] w_cnt_lo;
  logic [CW-1:0] w_cnt_hi;

  // Count the ones in the lower SIMD/2 lanes and in the upper SIMD-SIMD/2 lanes.
  always_comb begin
    w_cnt_lo = '0;
    w_cnt_hi = '0;
    for (int i = 0; i < SIMD / 2; i++) begin
      w_cnt_lo = w_cnt_lo + CW'(r_s0_bits[i]);
    end
    for (int i = SIMD / 2; i < SIMD; i++) begin
      w_cnt_hi = w_cnt_hi + CW'(r_s0_bits[i]);
    end
  end

  // Half sums as seen by the final adder, either direct or through the midpoint register
  logic          w_pc_v;
  logic          w_pc_first;
  logic          w_pc_last;
  logic [CW-1:0] w_pc_lo;
  logic [CW-1:0] w_pc_hi;

  generate
    if (PIPE_MID != 0) begin : g_mid
      logic          r_mid_v;
      logic          r_mid_first;
      logic          r_mid_last;
      logic [CW-1:0] r_mid_lo;
      logic [CW-1:0] r_mid_hi;

      // Register the two half sums to cut the popcount tree at its midpoint.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mid_v     <= 1'b0;
          r_mid_first <= 1'b0;
          r_mid_last  <= 1'b0;
          r_mid_lo    <= '0;
          r_mid_hi    <= '0;
        end else begin
          r_mid_v     <= r_s0_v;
          r_mid_first <= r_s0_first;
          r_mid_last  <= r_s0_last;
          r_mid_lo    <= w_cnt_lo;
          r_mid_hi    <= w_cnt_hi;
        end
      end

      assign w_pc_v     = r_mid_v;
      assign w_pc_first = r_mid_first;
      assign w_pc_last  = r_mid_last;
      assign w_pc_lo    = r_mid_lo;
      assign w_pc_hi    = r_mid_hi;
    end else begin : g_no_mid
      assign w_pc_v     = r_s0_v;
      assign w_pc_first = r_s0_first;
      assign w_pc_last  = r_s0_last;
      assign w_pc_lo    = w_cnt_lo;
      assign w_pc_hi    = w_cnt_hi;
    end
  endgenerate

  // Stage 1: final popcount
  logic          r_s1_v;
  logic          r_s1_first;
  logic          r_s1_last;
  logic [CW-1:0] r_s1_cnt;

  // Add the half sums; the total never exceeds SIMD, so it fits in CW bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v     <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_cnt   <= '0;
    end else begin
      r_s1_v     <= w_pc_v;
      r_s1_first <= w_pc_first;
      r_s1_last  <= w_pc_last;
      r_s1_cnt   <= w_pc_lo + w_pc_hi;
    end
  end

  // Accumulator stage
  logic [TDstI-1:0] r_acc;
  logic             r_acc_done;
  logic [TDstI-1:0] w_cnt_ext;
  logic [TDstI-1:0] w_acc_next;

  assign w_cnt_ext  = TDstI'(r_s1_cnt);
  assign w_acc_next = r_s1_first ? w_cnt_ext : r_acc + w_cnt_ext;

  // The first fold restarts the sum; the done flag marks the edge where a group completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_acc_done <= 1'b0;
    end else begin
      r_acc_done <= r_s1_v & r_s1_last;
      if (r_s1_v) begin
        r_acc <= w_acc_next;
      end
    end
  end

  // Output mapping of a completed sum
  logic [TDstI-1:0] w_f;

`ifdef MVU_PE_BIPOLAR_EN
  // Bipolar dot product: each agreeing lane is +1 and each disagreeing lane is -1.
  assign w_f = (r_acc << 1) - TDstI'(SIMD * SF);
`else
  assign w_f = r_acc;
`endif

  // Publish a completed group for one cycle; out_add holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_v   <= 1'b0;
      bus.out_add <= '0;
    end else begin
      bus.out_v <= r_acc_done;
      if (r_acc_done) begin
        bus.out_add <= w_f;
      end
    end
  end

endmodule

// File: tb/tb_mvu_pe_popcount_acc.sv
// Directed testbench for mvu_pe_popcount_acc. Five instances cover SF=1,
// SF=4 with and without the popcount midpoint register, SF=2, and an 8-bit
// result word for the bipolar build (macro MVU_PE_BIPOLAR_EN).
module tb_mvu_pe_popcount_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tb_v;
  logic [7:0] tb_bits;
  logic [4:0] sel;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  mvu_pe_popcount_acc_if #(.SIMD(8), .TDstI(16)) if0 ();
  mvu_pe_popcount_acc_if #(.SIMD(8), .TDstI(16)) if1 ();
  mvu_pe_popcount_acc_if #(.SIMD(8), .TDstI(16)) if2 ();
  mvu_pe_popcount_acc_if #(.SIMD(8), .TDstI(16)) if3 ();
  mvu_pe_popcount_acc_if #(.SIMD(8), .TDstI(8))  if4 ();

  assign if0.in_v = tb_v & sel[0];
  assign if1.in_v = tb_v & sel[1];
  assign if2.in_v = tb_v & sel[2];
  assign if3.in_v = tb_v & sel[3];
  assign if4.in_v = tb_v & sel[4];
  assign if0.in_bits = tb_bits;
  assign if1.in_bits = tb_bits;
  assign if2.in_bits = tb_bits;
  assign if3.in_bits = tb_bits;
  assign if4.in_bits = tb_bits;

  logic        ov[5];
  logic [15:0] oa[5];
  assign ov[0] = if0.out_v;
  assign ov[1] = if1.out_v;
  assign ov[2] = if2.out_v;
  assign ov[3] = if3.out_v;
  assign ov[4] = if4.out_v;
  assign oa[0] = if0.out_add;
  assign oa[1] = if1.out_add;
  assign oa[2] = if2.out_add;
  assign oa[3] = if3.out_add;
  assign oa[4] = {8'h00, if4.out_add};

  mvu_pe_popcount_acc #(.SIMD(8), .SF(1), .TDstI(16), .PIPE_MID(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(if0));
  mvu_pe_popcount_acc #(.SIMD(8), .SF(4), .TDstI(16), .PIPE_MID(0)) u_b (.clk(clk), .rst_n(rst_n), .bus(if1));
  mvu_pe_popcount_acc #(.SIMD(8), .SF(4), .TDstI(16), .PIPE_MID(1)) u_c (.clk(clk), .rst_n(rst_n), .bus(if2));
  mvu_pe_popcount_acc #(.SIMD(8), .SF(2), .TDstI(16), .PIPE_MID(0)) u_d (.clk(clk), .rst_n(rst_n), .bus(if3));
  mvu_pe_popcount_acc #(.SIMD(8), .SF(2), .TDstI(8),  .PIPE_MID(0)) u_e (.clk(clk), .rst_n(rst_n), .bus(if4));

  // Clock and edge counter
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: per instance, number of out_v pulses, edge count and value of the latest one.
  int          pcnt[5] = '{default: 0};
  int          pcyc[5] = '{default: 0};
  logic [15:0] padd[5] = '{default: 16'h0};

  always @(negedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (ov[i] === 1'b1) begin
        pcnt[i] <= pcnt[i] + 1;
        pcyc[i] <= cyc;
        padd[i] <= oa[i];
      end
    end
  end

  // Expected result for a popcount sum x over n lanes in a w-bit word.
  function automatic logic [15:0] fexp(input int x, input int n, input int w);
    int          v;
    logic [15:0] r;
`ifdef MVU_PE_BIPOLAR_EN
    v = 2 * x - n;
`else
    v = x;
`endif
    r = 16'(v);
    if (w == 8) r[15:8] = 8'h00;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle mid-cycle, then return just after the following falling edge.
  task automatic step(input logic [4:0] s, input logic v, input logic [7:0] b);
    sel     = s;
    tb_v    = v;
    tb_bits = b;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'b0, 1'b0, 8'h00);
  endtask

  int n0, n1, n2, k, k2, c_b;

  initial begin
    rst_n   = 1'b0;
    sel     = 5'b0;
    tb_v    = 1'b0;
    tb_bits = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("reset_out_v[%0d]", i), 32'(ov[i]), 32'd0);
      chk($sformatf("reset_out_add[%0d]", i), 32'(oa[i]), 32'd0);
    end
    rst_n = 1'b1;
    idle(2);

    // 1: SF=1, single full beat
    n0 = pcnt[0];
    step(5'b00001, 1'b1, 8'hFF);
    k = cyc;
    idle(8);
    chk("t1_pulses", 32'(pcnt[0] - n0), 32'd1);
    chk("t1_latency", 32'(pcyc[0] - k), 32'd3);
    chk("t1_out_add", 32'(padd[0]), 32'(fexp(8, 8, 16)));

    // 2: SF=4 back-to-back, PIPE_MID=0 (b) and PIPE_MID=1 (c)
    n1 = pcnt[1];
    n2 = pcnt[2];
    step(5'b00110, 1'b1, 8'h0F);
    step(5'b00110, 1'b1, 8'h01);
    step(5'b00110, 1'b1, 8'hFF);
    chk("t2_no_early_pulse", 32'(pcnt[1] - n1), 32'd0);
    step(5'b00110, 1'b1, 8'h00);
    k = cyc;
    idle(8);
    chk("t2_pulses_b", 32'(pcnt[1] - n1), 32'd1);
    chk("t2_latency_b", 32'(pcyc[1] - k), 32'd3);
    chk("t2_out_add_b", 32'(padd[1]), 32'(fexp(13, 32, 16)));
    chk("t2_pulses_c", 32'(pcnt[2] - n2), 32'd1);
    chk("t2_latency_c", 32'(pcyc[2] - k), 32'd4);
    chk("t2_out_add_c", 32'(padd[2]), 32'(fexp(13, 32, 16)));

    // 3: same beats with two idle cycles between them
    n1 = pcnt[1];
    n2 = pcnt[2];
    step(5'b00110, 1'b1, 8'h0F);
    idle(2);
    step(5'b00110, 1'b1, 8'h01);
    idle(2);
    step(5'b00110, 1'b1, 8'hFF);
    idle(2);
    chk("t3_no_early_pulse", 32'(pcnt[1] - n1), 32'd0);
    step(5'b00110, 1'b1, 8'h00);
    k = cyc;
    idle(8);
    chk("t3_pulses_b", 32'(pcnt[1] - n1), 32'd1);
    chk("t3_out_add_b", 32'(padd[1]), 32'(fexp(13, 32, 16)));
    chk("t3_pulses_c", 32'(pcnt[2] - n2), 32'd1);
    chk("t3_out_add_c", 32'(padd[2]), 32'(fexp(13, 32, 16)));
    chk("t3_latency_b", 32'(pcyc[1] - k), 32'd3);
    chk("t3_mid_delay", 32'(pcyc[2] - pcyc[1]), 32'd1);

    // 4: SF=2 continuous stream, two groups with no bubble
    n0 = pcnt[3];
    step(5'b01000, 1'b1, 8'hFF);
    step(5'b01000, 1'b1, 8'hFF);
    k2 = cyc;
    step(5'b01000, 1'b1, 8'h03);
    step(5'b01000, 1'b1, 8'h01);
    idle(1);
    chk("t4_first_pulses", 32'(pcnt[3] - n0), 32'd1);
    chk("t4_first_latency", 32'(pcyc[3] - k2), 32'd3);
    chk("t4_first_out_add", 32'(padd[3]), 32'(fexp(16, 16, 16)));
    c_b = pcyc[3];
    idle(8);
    chk("t4_second_pulses", 32'(pcnt[3] - n0), 32'd2);
    chk("t4_spacing", 32'(pcyc[3] - c_b), 32'd2);
    chk("t4_second_out_add", 32'(padd[3]), 32'(fexp(3, 16, 16)));

    // 6: 8-bit word, bipolar result when the macro is defined
    n0 = pcnt[4];
    step(5'b10000, 1'b1, 8'h00);
    step(5'b10000, 1'b1, 8'h00);
    idle(6);
    chk("t6_zero_out_add", 32'(padd[4]), 32'(fexp(0, 16, 8)));
    step(5'b10000, 1'b1, 8'hFF);
    step(5'b10000, 1'b1, 8'h0F);
    idle(6);
    chk("t6_mixed_out_add", 32'(padd[4]), 32'(fexp(12, 16, 8)));
    chk("t6_pulses", 32'(pcnt[4] - n0), 32'd2);

    // 5: asynchronous reset in the middle of a group
    chk("t5_pre_reset_out_add", 32'(oa[1]), 32'(fexp(13, 32, 16)));
    step(5'b00010, 1'b1, 8'hFF);
    step(5'b00010, 1'b1, 8'hFF);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_async_out_v", 32'(ov[1]), 32'd0);
    chk("t5_async_out_add", 32'(oa[1]), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    n1 = pcnt[1];
    step(5'b00010, 1'b1, 8'hFF);
    step(5'b00010, 1'b1, 8'hFF);
    step(5'b00010, 1'b1, 8'hFF);
    step(5'b00010, 1'b1, 8'hFF);
    k = cyc;
    idle(8);
    chk("t5_pulses", 32'(pcnt[1] - n1), 32'd1);
    chk("t5_latency", 32'(pcyc[1] - k), 32'd3);
    chk("t5_out_add", 32'(padd[1]), 32'(fexp(32, 32, 16)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
